// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD encoder between several requesters.
// Supervises the encoder handshake with start/busy timeouts and a start-low gap.
module bcd_conv_arbiter #(
    parameter int N_REQ      = 2,
    parameter int BINARY_LEN = 9,
    parameter int BCD_DIGITS = 3,
    parameter int BCD_LEN    = BCD_DIGITS * 4,
    parameter int START_TMO  = 8,
    parameter int BUSY_TMO   = BINARY_LEN + 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_REQ-1:0]            I_REQ,
    input  logic [N_REQ*BINARY_LEN-1:0] I_BIN,
    output logic [N_REQ-1:0]            O_DONE,
    output logic                        O_ERR,
    output logic [BCD_LEN-1:0]          O_BCD,
    output logic                        O_BUSY,
    output logic                        O_ENC_CONV,
    output logic [BINARY_LEN-1:0]       O_ENC_BIN,
    input  logic                        I_ENC_BUSY,
    input  logic [BCD_LEN-1:0]          I_ENC_BCD
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_MAX = (START_TMO > BUSY_TMO) ? START_TMO : BUSY_TMO;
    localparam int CNT_MAX = (TMO_MAX > GAP_CYCLES) ? TMO_MAX : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TMO - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TMO - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 conv_q, conv_d;
    logic [BINARY_LEN-1:0] bin_q, bin_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic                 err_q, err_d;
    logic [BCD_LEN-1:0]   bcd_q, bcd_d;
    logic                 busy_q, busy_d;

    logic [BINARY_LEN-1:0] bin_arr [N_REQ];
    logic [IDX_W:0]       rr_sum;
    logic [IDX_W-1:0]     rr_idx;
    logic [IDX_W-1:0]     pick;
    logic                 found;
    logic [N_REQ-1:0]     done_hot;

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign bin_arr[k] = I_BIN[k*BINARY_LEN +: BINARY_LEN];
    end

    // First active requester at or after the pointer, circularly
    always_comb begin
        pick   = '0;
        found  = 1'b0;
        rr_sum = '0;
        rr_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (rr_sum >= (IDX_W+1)'(N_REQ)) begin
                rr_sum = rr_sum - (IDX_W+1)'(N_REQ);
            end
            rr_idx = rr_sum[IDX_W-1:0];
            if (!found && I_REQ[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end

    assign done_hot = N_REQ'(1) << grant_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        grant_d = grant_q;
        ptr_d   = ptr_q;
        conv_d  = conv_q;
        bin_d   = bin_q;
        done_d  = '0;
        err_d   = 1'b0;
        bcd_d   = bcd_q;
        busy_d  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                // A busy encoder here belongs to someone else; wait it out
                if (found && !I_ENC_BUSY) begin
                    grant_d = pick;
                    ptr_d   = (pick == IDX_LAST) ? '0 : pick + IDX_W'(1);
                    bin_d   = bin_arr[pick];
                    conv_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                conv_d = 1'b1;
                if (I_ENC_BUSY) begin
                    conv_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else if (cnt_q == START_LAST) begin
                    conv_d  = 1'b0;
                    done_d  = done_hot;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_BUSY: begin
                if (!I_ENC_BUSY) begin
                    bcd_d   = I_ENC_BCD;
                    done_d  = done_hot;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == BUSY_LAST) begin
                    done_d  = done_hot;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                conv_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                conv_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            conv_q  <= 1'b0;
            bin_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            conv_q  <= conv_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
        end
    end

    assign O_DONE     = done_q;
    assign O_ERR      = err_q;
    assign O_BCD      = bcd_q;
    assign O_BUSY     = busy_q;
    assign O_ENC_CONV = conv_q;
    assign O_ENC_BIN  = bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural double-dabble encoder
// model (2-flop start edge detect, busy for BINARY_LEN+1 cycles).
module tb_bcd_conv_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  I_REQ = 2'b00;
    logic [8:0]  bin0 = '0;
    logic [8:0]  bin1 = '0;
    logic [17:0] I_BIN;
    logic [1:0]  O_DONE;
    logic        O_ERR;
    logic [11:0] O_BCD;
    logic        O_BUSY;
    logic        O_ENC_CONV;
    logic [8:0]  O_ENC_BIN;
    logic        I_ENC_BUSY;
    logic [11:0] I_ENC_BCD;

    int total = 0;
    int bad = 0;

    logic nobusy = 1'b0;
    logic stuck = 1'b0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;
    logic enc_busy = 1'b0;
    int   enc_cnt = 0;
    logic [8:0] enc_lat = '0;

    assign I_BIN = {bin1, bin0};
    assign I_ENC_BUSY = enc_busy;

    always #5 CLK = ~CLK;

    bcd_conv_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .I_REQ      (I_REQ),
        .I_BIN      (I_BIN),
        .O_DONE     (O_DONE),
        .O_ERR      (O_ERR),
        .O_BCD      (O_BCD),
        .O_BUSY     (O_BUSY),
        .O_ENC_CONV (O_ENC_CONV),
        .O_ENC_BIN  (O_ENC_BIN),
        .I_ENC_BUSY (I_ENC_BUSY),
        .I_ENC_BCD  (I_ENC_BCD)
    );

    function automatic logic [11:0] to_bcd(input logic [8:0] v);
        int x;
        x = int'(v);
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    assign I_ENC_BCD = to_bcd(enc_lat);

    always @(posedge CLK) begin
        s1 <= O_ENC_CONV;
        s2 <= s1;
        if (s1 && !s2 && !nobusy && !enc_busy) begin
            enc_busy <= 1'b1;
            enc_cnt  <= 0;
            enc_lat  <= O_ENC_BIN;
        end else if (enc_busy) begin
            if (enc_cnt >= 9 && !stuck) enc_busy <= 1'b0;
            else enc_cnt <= enc_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max, output int n,
                             output logic [1:0] d, output logic e);
        n = 0;
        while (O_DONE == 2'b00 && n < max) begin
            tick();
            n++;
        end
        if (O_DONE == 2'b00) n = -1;
        d = O_DONE;
        e = O_ERR;
    endtask

    task automatic finish_job(input string tag);
        tick();
        chk({tag, "_done_clr"}, 32'(O_DONE), 32'h0);
        chk({tag, "_err_clr"}, 32'(O_ERR), 32'h0);
        tick();
        tick();
        chk({tag, "_idle"}, 32'(O_BUSY), 32'h0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int g;
        logic [1:0] d;
        logic e;
        logic seen;

        tick();
        tick();
        chk("rst_done", 32'(O_DONE), 32'h0);
        chk("rst_err", 32'(O_ERR), 32'h0);
        chk("rst_bcd", 32'(O_BCD), 32'h0);
        chk("rst_busy", 32'(O_BUSY), 32'h0);
        chk("rst_conv", 32'(O_ENC_CONV), 32'h0);
        chk("rst_bin", 32'(O_ENC_BIN), 32'h0);
        RST = 1'b0;
        tick();

        // 1: single request, nominal latency
        bin0 = 9'd347;
        I_REQ = 2'b01;
        tick();
        chk("t1_busy", 32'(O_BUSY), 32'h1);
        chk("t1_conv", 32'(O_ENC_CONV), 32'h1);
        chk("t1_bin", 32'(O_ENC_BIN), 32'd347);
        wait_done(40, n, d, e);
        I_REQ = 2'b00;
        chk("t1_lat", 32'(n), 32'd13);
        chk("t1_done", 32'(d), 32'h1);
        chk("t1_err", 32'(e), 32'h0);
        chk("t1_bcd", 32'(O_BCD), 32'h347);
        finish_job("t1");

        // 2: both requesting, round-robin alternation with gap
        do_reset();
        bin0 = 9'd0;
        bin1 = 9'd511;
        I_REQ = 2'b11;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_bin", 32'(O_ENC_BIN), (k % 2 == 0) ? 32'd0 : 32'd511);
            wait_done(40, n, d, e);
            chk("t2_lat", 32'(n), 32'd13);
            chk("t2_done", 32'(d), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("t2_err", 32'(e), 32'h0);
            chk("t2_bcd", 32'(O_BCD), (k % 2 == 0) ? 32'h000 : 32'h511);
            if (k < 3) begin
                g = 0;
                while (!O_ENC_CONV && g < 20) begin
                    tick();
                    g++;
                end
                chk("t2_gap", 32'(g), 32'd3);
            end
        end
        I_REQ = 2'b00;
        finish_job("t2");

        // 3: encoder never answers -> start timeout
        nobusy = 1'b1;
        bin0 = 9'd123;
        I_REQ = 2'b01;
        tick();
        wait_done(40, n, d, e);
        I_REQ = 2'b00;
        chk("t3_lat", 32'(n), 32'd8);
        chk("t3_done", 32'(d), 32'h1);
        chk("t3_err", 32'(e), 32'h1);
        chk("t3_bcd", 32'(O_BCD), 32'h511);
        chk("t3_conv", 32'(O_ENC_CONV), 32'h0);
        finish_job("t3");
        nobusy = 1'b0;

        // 4: busy stuck high -> busy timeout, then no grant while busy
        stuck = 1'b1;
        bin1 = 9'd200;
        I_REQ = 2'b10;
        tick();
        chk("t4_bin", 32'(O_ENC_BIN), 32'd200);
        wait_done(40, n, d, e);
        chk("t4_lat", 32'(n), 32'd16);
        chk("t4_done", 32'(d), 32'h2);
        chk("t4_err", 32'(e), 32'h1);
        chk("t4_bcd", 32'(O_BCD), 32'h511);
        bin0 = 9'd42;
        I_REQ = 2'b01;
        tick();
        tick();
        tick();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (O_BUSY || O_ENC_CONV) seen = 1'b1;
        end
        chk("t4_nogrant", 32'(seen), 32'h0);
        stuck = 1'b0;
        wait_done(40, n, d, e);
        I_REQ = 2'b00;
        chk("t4_lat2", 32'(n), 32'd15);
        chk("t4_done2", 32'(d), 32'h1);
        chk("t4_err2", 32'(e), 32'h0);
        chk("t4_bcd2", 32'(O_BCD), 32'h042);
        finish_job("t4");

        // 5: reset in the middle of a busy job
        bin0 = 9'd99;
        I_REQ = 2'b01;
        tick();
        for (int k = 0; k < 5; k++) tick();
        chk("t5_pre_busy", 32'(O_BUSY), 32'h1);
        RST = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(O_BUSY), 32'h0);
        chk("t5_rst_conv", 32'(O_ENC_CONV), 32'h0);
        chk("t5_rst_done", 32'(O_DONE), 32'h0);
        chk("t5_rst_err", 32'(O_ERR), 32'h0);
        chk("t5_rst_bcd", 32'(O_BCD), 32'h0);
        chk("t5_rst_bin", 32'(O_ENC_BIN), 32'h0);
        tick();
        RST = 1'b0;
        tick();
        chk("t5_wait_enc", 32'(O_BUSY), 32'h0);
        wait_done(60, n, d, e);
        I_REQ = 2'b00;
        chk("t5_lat", 32'(n), 32'd19);
        chk("t5_done", 32'(d), 32'h1);
        chk("t5_err", 32'(e), 32'h0);
        chk("t5_bcd", 32'(O_BCD), 32'h099);
        finish_job("t5");

        // 6: lone request on req 1 at pointer 0; req dropped after grant
        do_reset();
        bin0 = 9'd5;
        bin1 = 9'd256;
        I_REQ = 2'b10;
        tick();
        chk("t6_busy", 32'(O_BUSY), 32'h1);
        chk("t6_bin", 32'(O_ENC_BIN), 32'd256);
        wait_done(40, n, d, e);
        I_REQ = 2'b00;
        chk("t6_done", 32'(d), 32'h2);
        chk("t6_bcd", 32'(O_BCD), 32'h256);
        finish_job("t6");
        bin0 = 9'd77;
        I_REQ = 2'b01;
        tick();
        chk("t6_bin2", 32'(O_ENC_BIN), 32'd77);
        I_REQ = 2'b00;
        wait_done(40, n, d, e);
        chk("t6_lat2", 32'(n), 32'd13);
        chk("t6_done2", 32'(d), 32'h1);
        chk("t6_err2", 32'(e), 32'h0);
        chk("t6_bcd2", 32'(O_BCD), 32'h077);
        finish_job("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
